// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I front end: data width, the canonical NOP,
// the default reset PC, the fetch state encoding and the instruction buffer
// entry layout. Also provides the PC alignment helper.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch engine states: no read outstanding / live read outstanding /
  // stale read outstanding that must be swallowed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Word-align an address by clearing its two low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo
// Synchronous FIFO of fetch entries ({instruction, pc}) between the fetch
// engine and the decoder. Flush empties the FIFO and wins over a same-cycle
// push or pop. A push while full is accepted only together with a pop.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push_i/wdata_i: write an entry
//   pop_i         : retire the head entry
//   flush_i       : discard all entries
//   head_o        : entry at the head (storage reset to NOP / pc 0)
//   count_o       : current occupancy
//   full_o/empty_o: registered occupancy flags
// ---------------------------------------------------------------------------
module inst_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  // Next pointer/occupancy values; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage, pointers and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{inst: NOP_INST, pc: 32'h0000_0000};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == {CW{1'b0}});
      if (do_push && !flush_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// RV32I instruction fetch stage. Owns the PC, issues word reads to
// instruction memory (at most one outstanding), buffers returned words in
// inst_fifo and hands {inst, pc} to the decoder over valid/ready. A redirect
// retargets the PC, flushes the buffer and discards any in-flight response.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect with redirect_pc[1:0] != 0 sets sticky misalign_err
//               and halts fetch until the next aligned redirect.
//   undefined : the low target bits are dropped and misalign_err is 0.
//
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt       : memory request port (addr = pc)
//   imem_rvalid/imem_rdata            : in-order read response
//   inst_valid/inst/inst_pc/inst_ready: decoder handshake (registered)
//   redirect_e/redirect_pc            : retarget from execute
//   misalign_err                      : sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_e,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          req_raw, push, flush, pop, halt;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] count;
  logic [CW:0]   occ_after;
  logic          room_now, room_after_push;
  fetch_entry_t  head;
  fetch_entry_t  wentry;

  assign pop       = inst_valid && inst_ready;
  assign room_now  = !fifo_full;
  // Occupancy after this cycle's response push and any decoder pop; lets a
  // single-cycle memory sustain one instruction per cycle.
  assign occ_after = {1'b0, count} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, pop};
  assign room_after_push = (occ_after < {1'b0, DEPTH_C});

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_q;
  logic misalign_q;
  logic redir_misaligned;

  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);

  // Halt latch and sticky error; every redirect re-decides the halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else if (redirect_e) begin
      halt_q     <= redir_misaligned;
      misalign_q <= misalign_q | redir_misaligned;
    end else begin
      halt_q     <= halt_q;
      misalign_q <= misalign_q;
    end
  end

  assign halt         = halt_q;
  assign misalign_err = misalign_q;
`else
  assign halt         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Fetch engine: request generation, response push and state/PC update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    req_raw   = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    if (redirect_e) begin
      // A response landing in this cycle completes the old read, so only a
      // still-pending read leaves something to swallow.
      flush = 1'b1;
      pc_d  = align_pc(redirect_pc);
      if ((state_q != IDLE) && !imem_rvalid) begin
        state_d = DROP;
      end else begin
        state_d = IDLE;
      end
    end else if (halt) begin
      // Halted: let a stale read drain, never issue new ones.
      if ((state_q != IDLE) && imem_rvalid) begin
        state_d = IDLE;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        IDLE: req_raw = room_now;
        WAIT: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            req_raw = room_after_push;
          end else begin
            req_raw = 1'b0;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            req_raw = room_now;
          end else begin
            req_raw = 1'b0;
          end
        end
        default: req_raw = 1'b0;
      endcase
      if (req_raw && imem_gnt) begin
        state_d   = WAIT;
        pend_pc_d = pc_q;
        pc_d      = pc_q + 32'd4;
      end else if ((state_q != IDLE) && imem_rvalid) begin
        state_d = IDLE;
      end else begin
        state_d = state_q;
      end
    end
  end

  // State, PC and pending-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign imem_req  = req_raw && !rst;
  assign imem_addr = pc_q;
  assign wentry    = '{inst: imem_rdata, pc: pend_pc_q};

  inst_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import rv32i_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_e;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_e(redirect_e), .redirect_pc(redirect_pc), .misalign_err(misalign_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_9613;
  endfunction

  // ---------------- reference model state ----------------
  logic [31:0] q[$];          // PCs the decoder should see, in order
  bit          mem_busy, mem_stale;
  int          mem_left;
  logic [31:0] mem_addr, exp_fetch;
  bit          halted, err_exp;
  bit          prev_req, prev_gnt;
  logic [31:0] prev_addr;
  int          gnt_pct, rdy_pct, lat_min, lat_max;
  bit          s_req, s_gnt, s_ival, s_err;
  logic [31:0] s_addr, s_ipc;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect_e = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, NOP_INST);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_misalign_err", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    q.delete(); mem_busy = 0; mem_stale = 0; mem_left = 0; mem_addr = 32'h0;
    exp_fetch = 32'h0; halted = 0; err_exp = 0; prev_req = 0; prev_gnt = 0; prev_addr = 32'h0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check the
  // request against the model's rules, then advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit force_rv);
    bit rv, pushv, pop, exp_req, outstanding, room;
    int sz;
    @(negedge clk);
    sz = q.size();
    check("inst_valid", 32'(inst_valid), 32'(sz != 0));
    if (sz != 0) begin
      check("inst_pc", inst_pc, q[0]);
      check("inst", inst, data_of(q[0]));
    end
    check("misalign_err", 32'(misalign_err), 32'(err_exp));
    if (mem_busy) mem_left--;
    rv = (mem_busy && mem_left == 0) || force_rv;
    redirect_e  = redir;
    redirect_pc = rpc;
    inst_ready  = ($urandom_range(99) < rdy_pct);
    imem_rvalid = rv;
    imem_rdata  = rv ? (mem_busy ? data_of(mem_addr) : 32'hDEAD_BEEF) : $urandom;
    imem_gnt    = 1'b0;
    #1;
    pop         = (sz != 0) && inst_ready;
    pushv       = rv && mem_busy && !mem_stale && !redir;
    outstanding = mem_busy && !rv;
    room        = pushv ? (sz + 1 - int'(pop) < DEPTH) : (sz < DEPTH);
    exp_req     = !redir && !halted && !outstanding && room;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_fetch);
    if (prev_req && !prev_gnt && !redir) check("stall_addr_hold", imem_addr, prev_addr);
    imem_gnt = ($urandom_range(99) < gnt_pct);
    #1;
    s_req = imem_req; s_gnt = imem_gnt; s_addr = imem_addr;
    s_ival = inst_valid; s_ipc = inst_pc; s_err = misalign_err;
    if (pop) void'(q.pop_front());
    if (rv && mem_busy) mem_busy = 0;
    if (pushv) q.push_back(mem_addr);
    if (redir) begin
      q.delete();
      exp_fetch = {rpc[31:2], 2'b00};
      if (mem_busy) mem_stale = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) begin
        err_exp = 1; halted = 1;
      end else begin
        halted = 0;
      end
`endif
    end
    if (imem_req && imem_gnt) begin
      mem_busy = 1; mem_stale = 0; mem_addr = imem_addr;
      mem_left = $urandom_range(lat_max, lat_min);
      exp_fetch = exp_fetch + 32'd4;
    end
    prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr;
    @(posedge clk);
  endtask

  task automatic knobs(input int g, input int r, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; lat_min = lmin; lat_max = lmax;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        gnt, rv, rdy;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t tv[15];

  initial begin
    bit got_g, got_i;
    logic [31:0] rpc;

    // Single-cycle memory, decoder stalls for 5 cycles then resumes.
    tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    tv[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 32'd12};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'd12};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'd12};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'd12};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'd12};
    tv[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
    tv[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd16};
    tv[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd24, 1'b0, 32'd0};
    tv[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd20};
    tv[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd32, 1'b1, 32'd24};

    knobs(100, 100, 1, 1);
    do_reset();
    for (int k = 0; k < 15; k++) begin
      imem_gnt = tv[k].gnt; imem_rvalid = tv[k].rv; inst_ready = tv[k].rdy;
      imem_rdata = 32'h0050_0093; redirect_e = 1'b0;
      #1;
      check($sformatf("tbl%0d_req", k), 32'(imem_req), 32'(tv[k].req));
      if (tv[k].req) check($sformatf("tbl%0d_addr", k), imem_addr, tv[k].addr);
      check($sformatf("tbl%0d_valid", k), 32'(inst_valid), 32'(tv[k].iv));
      if (tv[k].iv) begin
        check($sformatf("tbl%0d_pc", k), inst_pc, tv[k].ipc);
        check($sformatf("tbl%0d_inst", k), inst, 32'h0050_0093);
      end
      @(negedge clk);
    end

    // Redirect while a 3-cycle read is in flight.
    do_reset(); knobs(100, 100, 3, 3);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b0);
    got_g = 0; got_i = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (s_req && s_gnt && !got_g) begin got_g = 1; check("t3_first_req", s_addr, 32'h100); end
      if (s_ival && !got_i) begin got_i = 1; check("t3_first_pc", s_ipc, 32'h100); end
    end
    check("t3_progress", 32'({got_g, got_i}), 32'd3);

    // Redirect with the buffer full and an rvalid in the same cycle.
    do_reset(); knobs(100, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    check("t4_full_req", 32'(s_req), 32'd0);
    check("t4_full_valid", 32'(s_ival), 32'd1);
    step(1'b1, 32'h0000_0300, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    check("t4_flushed", 32'(s_ival), 32'd0);
    knobs(100, 100, 1, 1);
    got_i = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (s_ival && !got_i) begin got_i = 1; check("t4_first_pc", s_ipc, 32'h300); end
    end
    check("t4_progress", 32'(got_i), 32'd1);

    // Grant stall for several cycles.
    do_reset(); knobs(0, 100, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0);
      check("t5_req_held", 32'(s_req), 32'd1);
      check("t5_addr_held", s_addr, 32'h0);
    end
    knobs(100, 100, 1, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);

    // Misaligned redirect.
    do_reset(); knobs(100, 100, 1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0102, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b0);
      check("t6_err_set", 32'(s_err), 32'd1);
      check("t6_halted_req", 32'(s_req), 32'd0);
    end
    step(1'b1, 32'h0000_0200, 1'b0);
    got_i = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (s_ival && !got_i) begin got_i = 1; check("t6_resume_pc", s_ipc, 32'h200); end
    end
    check("t6_err_sticky", 32'(s_err), 32'd1);
    check("t6_progress", 32'(got_i), 32'd1);
`else
    got_i = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (s_ival && !got_i) begin got_i = 1; check("t6_aligned_pc", s_ipc, 32'h100); end
    end
    check("t6_err_zero", 32'(s_err), 32'd0);
    check("t6_progress", 32'(got_i), 32'd1);
`endif

    // Randomized traffic against the model, including PC wrap targets.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: knobs(100, 100, 1, 1);
        1: knobs(70, 60, 1, 3);
        2: knobs(40, 90, 2, 4);
        default: knobs(90, 20, 1, 2);
      endcase
      for (int i = 0; i < 700; i++) begin
        case ($urandom_range(3))
          0: rpc = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
          1: rpc = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(3));
          default: rpc = $urandom & 32'h0000_FFFC;
        endcase
        step($urandom_range(99) < 3, rpc, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
